io_port_bridge: RTL

//  Sits between the cpu memory bus and RAM/UART. Decodes each access by mem_a[17:16]: 2'b11 goes to
//  I/O, everything else passes to RAM. Owns the TX byte FIFO that drives io_buffer_full, RX byte pop,
//  the 32-bit cycle counter at 0x30004, and the program-stop flag. Read data returns one cycle after
//  the request, matching the RAM timing the cpu expects.

---
 rtl/io_port_bridge.sv | 116 +++++++++++
 1 files changed

// File: rtl/io_port_bridge.sv
// CPU bus bridge: decodes RAM vs. memory-mapped I/O, owns the TX byte FIFO,
// RX pop, the free-running cycle counter with snapshot, and the halt flag.
module io_port_bridge #(
  parameter int unsigned TX_DEPTH    = 8,
  parameter int unsigned FULL_MARGIN = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [16:0] ram_a,
  output logic [7:0]  ram_din,
  output logic        ram_we,
  input  logic [7:0]  ram_dout,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_pop,
  output logic        halted,
  output logic        tx_overflow
);

  localparam int unsigned PTR_W = $clog2(TX_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [7:0]       fifo [TX_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count, count_next;
  logic [31:0]      cycle_cnt, snap;
  logic             rsel_io;
  logic [7:0]       io_byte, io_byte_next;

  logic io, acc_io, a_rx, a_cnt, push, pop, accept, snap_rd, halt_wr;
  logic [7:0] push_data;
  logic unused_bits;

  assign unused_bits = &{1'b0, mem_a[31:18]};

  // Address decode and TX FIFO push/pop qualification
  always_comb begin
    io         = (mem_a[17:16] == 2'b11);
    acc_io     = rdy_in & io;
    a_rx       = (mem_a[15:0] == 16'h0000);
    a_cnt      = (mem_a[15:2] == 14'h0001);
    snap_rd    = acc_io & ~mem_wr & a_cnt & (mem_a[1:0] == 2'b00);
    halt_wr    = acc_io &  mem_wr & a_cnt & (mem_a[1:0] == 2'b00);
    push       = (acc_io & mem_wr & a_rx & (mem_dout != 8'h00)) | halt_wr;
    push_data  = a_rx ? mem_dout : 8'h00;
    pop        = tx_valid & tx_ready;
    accept     = push & ((count != CNT_W'(TX_DEPTH)) | pop);
    count_next = count + CNT_W'(accept) - CNT_W'(pop);
  end

  // Read byte for I/O addresses; byte 0 of the counter sees the fresh snapshot
  always_comb begin
    io_byte_next = 8'h00;
    if (a_rx) begin
      io_byte_next = rx_valid ? rx_data : 8'h00;
    end else if (a_cnt) begin
      case (mem_a[1:0])
        2'd0:    io_byte_next = cycle_cnt[7:0];
        2'd1:    io_byte_next = snap[15:8];
        2'd2:    io_byte_next = snap[23:16];
        default: io_byte_next = snap[31:24];
      endcase
    end
  end

  assign rx_pop  = acc_io & ~mem_wr & a_rx & rx_valid & ~rst_in;
  assign ram_a   = mem_a[16:0];
  assign ram_din = mem_dout;
  assign ram_we  = mem_wr & rdy_in & ~io;
  assign mem_din = rsel_io ? io_byte : ram_dout;
  assign tx_data = fifo[rd_ptr];

  always_ff @(posedge clk_in) begin
    if (accept) fifo[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      cycle_cnt      <= '0;
      snap           <= '0;
      rsel_io        <= 1'b1;
      io_byte        <= 8'h00;
      tx_valid       <= 1'b0;
      io_buffer_full <= 1'b0;
      halted         <= 1'b0;
      tx_overflow    <= 1'b0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (snap_rd) snap <= cycle_cnt;
      if (rdy_in) begin
        rsel_io <= io;
        io_byte <= io_byte_next;
      end
      if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
      count          <= count_next;
      tx_valid       <= (count_next != '0);
      io_buffer_full <= (count_next >= CNT_W'(TX_DEPTH - FULL_MARGIN));
      if (push & ~accept) tx_overflow <= 1'b1;
      if (halt_wr)        halted      <= 1'b1;
    end
  end

endmodule
